// File: rtl/input_cache_mp.sv
// input_cache_mp: NBK-bank burst-filled byte-read cache for fpmac; define INPUT_CACHE_PREFETCH_EN for next-line prefetch.
module input_cache_mp #(
  parameter int NBK  = 32,
  parameter int NTFR = 64,
  parameter int AW   = 24,
  parameter int MDW  = 64
) (
  input  logic           clk,
  input  logic           xrst,
  input  logic           civ,
  input  logic           re,
  input  logic [AW-1:0]  adr,
  output logic [7:0]     dr,
  output logic           rdy,
  output logic           rreq,
  input  logic           rack,
  output logic [AW-1:0]  radr,
  input  logic [MDW-1:0] rdata
);
  localparam int BPB = MDW / 8;
  localparam int LB  = $clog2(NTFR * BPB);
  localparam int BB  = $clog2(BPB);
  localparam int KB  = $clog2(NBK);
  localparam int TB  = $clog2(NTFR);
  localparam int TW  = AW - LB;
  typedef enum logic [1:0] {IDLE, WAIT_ACK, FILL, DRAIN} state_t;
  state_t state, state_n;
  logic [TW-1:0] tag [NBK];
  logic [NBK-1:0] valid, full;
  logic [KB-1:0] victim, fill_bank, hb, alloc_bank;
  logic [TB-1:0] cnt;
  logic [LB:0] wpt;
  logic [TW-1:0] line, alloc_tag;
  logic hit, rdy_i, alloc, bump, wr, last, busy;
  logic [MDW-1:0] mem [NBK*NTFR];
  logic [MDW-1:0] rword;
  assign line  = adr[AW-1:LB];
  assign last  = cnt == TB'(NTFR - 1);
  assign busy  = state == WAIT_ACK || state == FILL;
  assign wr    = busy && rack;
  assign rword = mem[{hb, adr[LB-1:BB]}];
  // lowest hitting bank wins if tags were ever duplicated
  always_comb begin
    hit = 1'b0;
    hb  = '0;
    for (int i = NBK - 1; i >= 0; i--)
      if (re && valid[i] && tag[i] == line) begin
        hit = 1'b1;
        hb  = KB'(i);
      end
  end
  assign rdy_i = !re || (hit && (full[hb] || (hb == fill_bank && {1'b0, adr[LB-1:0]} < wpt)));
`ifdef INPUT_CACHE_PREFETCH_EN
  logic pf_pend, pf_cur, pf_res, pf_alloc;
  logic [TW-1:0] pf_line;
  assign pf_line = tag[fill_bank] + 1'b1;
  always_comb begin
    pf_res = 1'b0;
    for (int i = 0; i < NBK; i++)
      if (valid[i] && tag[i] == pf_line) pf_res = 1'b1;
  end
  // pf_pend is high for exactly the Idle cycle after a demand fill completes
  always_ff @(posedge clk or negedge xrst)
    if (!xrst) begin
      pf_pend <= 1'b0;
      pf_cur  <= 1'b0;
    end else begin
      pf_pend <= wr && last && !civ && !pf_cur;
      if (alloc) pf_cur <= pf_alloc;
    end
`endif
  always_comb begin
    state_n    = state;
    alloc      = 1'b0;
    bump       = 1'b0;
    alloc_bank = victim;
    alloc_tag  = line;
`ifdef INPUT_CACHE_PREFETCH_EN
    pf_alloc   = 1'b0;
`endif
    case (state)
      IDLE:
        if (!civ && re && (!hit || (!full[hb] && hb != fill_bank))) begin
          alloc      = 1'b1;
          bump       = !hit;
          alloc_bank = hit ? hb : victim;
          state_n    = WAIT_ACK;
        end
`ifdef INPUT_CACHE_PREFETCH_EN
        else if (!civ && pf_pend && !pf_res && !(&tag[fill_bank])) begin
          alloc     = 1'b1;
          bump      = 1'b1;
          pf_alloc  = 1'b1;
          alloc_tag = pf_line;
          state_n   = WAIT_ACK;
        end
`endif
      WAIT_ACK, FILL:
        state_n = civ ? (rack && last ? IDLE : DRAIN) : (rack ? (last ? IDLE : FILL) : state);
      default:
        state_n = rack && last ? IDLE : DRAIN;
    endcase
  end
  always_ff @(posedge clk or negedge xrst)
    if (!xrst) begin
      state     <= IDLE;
      valid     <= '0;
      full      <= '0;
      victim    <= '0;
      fill_bank <= '0;
      cnt       <= '0;
      wpt       <= '0;
      rreq      <= 1'b0;
      radr      <= '0;
      rdy       <= 1'b0;
      dr        <= '0;
    end else begin
      state <= state_n;
      rdy   <= rdy_i;
      if (re) dr <= rword[{adr[BB-1:0], 3'b000} +: 8];
      if (civ) begin
        valid  <= '0;
        full   <= '0;
        victim <= '0;
      end else begin
        if (alloc) begin
          valid[alloc_bank] <= 1'b1;
          full[alloc_bank]  <= 1'b0;
        end
        if (wr && last) full[fill_bank] <= 1'b1;
        if (bump) victim <= victim + 1'b1;
      end
      if (alloc) begin
        fill_bank <= alloc_bank;
        radr      <= {alloc_tag, LB'(0)};
        rreq      <= 1'b1;
        cnt       <= '0;
        wpt       <= '0;
      end else if (rack && state != IDLE) begin
        rreq <= 1'b0;
        cnt  <= cnt + 1'b1;
        if (wr) wpt <= wpt + (LB+1)'(BPB);
      end
    end
  // drained beats are counted by the FSM but never reach the RAM
  always_ff @(posedge clk) begin
    if (wr) mem[{fill_bank, cnt}] <= rdata;
    if (alloc) tag[alloc_bank] <= alloc_tag;
  end
endmodule

// File: tb/tb_input_cache_mp.sv
// tb_input_cache_mp: randomized reads against a line-level cache model with a burst memory responder.
module tb_input_cache_mp;
  localparam int NBK = 4, NTFR = 8, AW = 24, MDW = 64, LB = 6;
  logic clk = 1'b0, xrst = 1'b0, civ = 1'b0, re = 1'b0, rack = 1'b0;
  logic rreq, rdy;
  logic [AW-1:0] adr = '0, radr;
  logic [7:0] dr;
  logic [MDW-1:0] rdata = '0;
  int checks = 0, failures = 0;
  bit gap_en = 1'b0, r_active = 1'b0;
  int beats_total = 0, bursts = 0, last_lat = 0;
  logic [AW-1:0] exp_q[$];
  int m_tag[NBK];
  bit m_valid[NBK];
  int m_vic = 0;
  always #5 clk = ~clk;
  input_cache_mp #(.NBK(NBK), .NTFR(NTFR), .AW(AW), .MDW(MDW)) dut (
    .clk(clk), .xrst(xrst), .civ(civ), .re(re), .adr(adr), .dr(dr), .rdy(rdy),
    .rreq(rreq), .rack(rack), .radr(radr), .rdata(rdata));
  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] f(input logic [AW-1:0] a);
    return (a[7:0] * 8'd29) ^ a[15:8] ^ 8'h5A;
  endfunction
  function automatic logic [MDW-1:0] beat_data(input logic [AW-1:0] base, input int beat);
    logic [MDW-1:0] d;
    for (int k = 0; k < MDW / 8; k++) d[k*8 +: 8] = f(AW'(base + beat * 8 + k));
    return d;
  endfunction
  function automatic bit m_hit(input int ln);
    for (int i = 0; i < NBK; i++) if (m_valid[i] && m_tag[i] == ln) return 1'b1;
    return 1'b0;
  endfunction
  function automatic void m_alloc(input int ln);
    m_tag[m_vic] = ln;
    m_valid[m_vic] = 1'b1;
    m_vic = (m_vic + 1) % NBK;
    exp_q.push_back(AW'(ln << LB));
  endfunction
  function automatic void m_clear();
    for (int i = 0; i < NBK; i++) m_valid[i] = 1'b0;
    m_vic = 0;
  endfunction
  // memory side: serves one NTFR-beat burst per request, aborts on reset
  initial begin
    logic [AW-1:0] base;
    int beat;
    base = '0;
    beat = 0;
    forever begin
      @(posedge clk);
      #1;
      rack = 1'b0;
      if (!xrst) r_active = 1'b0;
      else begin
        if (!r_active && rreq) begin
          r_active = 1'b1;
          base = radr;
          beat = 0;
          bursts++;
          if (exp_q.size() == 0) chk("unexp_req", rreq, 0);
          else chk("radr", radr, exp_q.pop_front());
        end
        if (r_active && (!gap_en || $urandom_range(0, 2) != 0)) begin
          rack = 1'b1;
          rdata = beat_data(base, beat);
          beat++;
          beats_total++;
          if (beat == NTFR) r_active = 1'b0;
        end
      end
    end
  end
  task automatic do_read(input logic [AW-1:0] a);
    int n;
    bit h, hchk;
    h = m_hit(int'(a >> LB));
    hchk = h && !(r_active || rack || rreq || civ);
    if (!h) m_alloc(int'(a >> LB));
    re = 1'b1;
    adr = a;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!rdy && n < 300);
    chk("rd_rdy", rdy, 1);
    if (rdy) chk("rd_dr", dr, f(a));
    if (hchk) chk("hit_lat", n, 1);
    last_lat = n;
  endtask
  task automatic settle();
    int n;
    re = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while ((r_active || rack || rreq) && n < 300);
    chk("settle", r_active || rack || rreq, 0);
    @(posedge clk);
    #2;
  endtask
  task automatic civ_pulse();
    settle();
    civ = 1'b1;
    @(posedge clk);
    #2;
    civ = 1'b0;
    m_clear();
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, b0, bu0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_rreq", rreq, 0);
    chk("rst_rdy", rdy, 0);
    chk("rst_dr", dr, 0);
    chk("rst_radr", radr, 0);
    @(negedge clk) xrst = 1'b1;
    @(posedge clk);
    #2;
    chk("idle_rdy", rdy, 1);
    m_clear();
`ifdef INPUT_CACHE_PREFETCH_EN
    do_read(24'h000100);
    re = 1'b0;
    m_alloc(int'(24'h000140 >> LB));
    n = 0;
    while (bursts < 2 && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("pf_bursts", bursts, 2);
    settle();
    do_read(24'h000140);
`else
    do_read(24'h000123);
    chk("cold_lat", last_lat, 7);
    settle();
    for (int i = 0; i < 64; i++) begin
      do_read(AW'(24'h000100 + i));
      chk("stream_rreq", rreq, 0);
    end
    civ_pulse();
    for (int i = 1; i <= 5; i++) do_read(AW'(i * 24'h000100));
    do_read(24'h000100);
    settle();
    do_read(24'h000300);
    do_read(24'h000200);
    chk("repl_miss", last_lat > 1, 1);
    civ_pulse();
    m_alloc(int'(24'h000100 >> LB));
    bu0 = bursts;
    b0 = beats_total;
    re = 1'b1;
    adr = 24'h000100;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (beats_total < b0 + 4 && n < 100);
    civ = 1'b1;
    @(posedge clk);
    #2;
    civ = 1'b0;
    m_clear();
    m_alloc(int'(24'h000100 >> LB));
    @(posedge clk);
    #2;
    chk("drain_rdy", rdy, 0);
    n = 0;
    while (!rdy && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("civ_refill_rdy", rdy, 1);
    chk("civ_refill_dr", dr, f(24'h000100));
    chk("civ_bursts", bursts, bu0 + 2);
    settle();
    do_read(24'h000200);
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    @(negedge clk);
    xrst = 1'b0;
    #1;
    chk("arst_rdy", rdy, 0);
    chk("arst_rreq", rreq, 0);
    chk("arst_dr", dr, 0);
    re = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    xrst = 1'b1;
    m_clear();
    exp_q.delete();
    @(posedge clk);
    #2;
    do_read(24'h000200);
    chk("rst_miss", last_lat > 1, 1);
    gap_en = 1'b1;
    for (int it = 0; it < 300; it++) begin
      int r;
      r = $urandom_range(0, 15);
      if (r == 0) civ_pulse();
      else if (r == 1) settle();
      do_read(AW'(24'h000800 + $urandom_range(0, 5) * 64 + $urandom_range(0, 63)));
    end
`endif
    settle();
    chk("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
